axil2wb: RTL and testbench

- AXI4-Lite slave to Wishbone classic master bridge. Reverse direction of the team's Wishbone-to-AXI-Lite bridge.
- Lets an AXI-Lite initiator (FIR testbench host, DMA) reach Wishbone-mapped user-project registers.
- One transaction in flight. Registered Wishbone outputs. Ack timeout returns SLVERR instead of hanging the bus.

---
 rtl/axil_wb_pkg.sv | 19 +
 rtl/axil2wb.sv | 158 +++++++++++++++
 tb/tb_axil2wb.sv | 383 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_wb_pkg.sv
// Shared types and constants for the AXI4-Lite to Wishbone classic bridge.
package axil_wb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WB_WR,
    WB_RD,
    B_RESP,
    R_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/axil2wb.sv
// AXI4-Lite slave to Wishbone classic master bridge, one transaction in flight,
// with an ack timeout that turns a silent slave into SLVERR.
module axil2wb
  import axil_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int TIMEOUT    = 255
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_i,
  input  logic [ADDR_WIDTH-1:0]   axil_awaddr,
  input  logic                    axil_awvalid,
  output logic                    axil_awready,
  input  logic [DATA_WIDTH-1:0]   axil_wdata,
  input  logic [DATA_WIDTH/8-1:0] axil_wstrb,
  input  logic                    axil_wvalid,
  output logic                    axil_wready,
  output logic [1:0]              axil_bresp,
  output logic                    axil_bvalid,
  input  logic                    axil_bready,
  input  logic [ADDR_WIDTH-1:0]   axil_araddr,
  input  logic                    axil_arvalid,
  output logic                    axil_arready,
  output logic [DATA_WIDTH-1:0]   axil_rdata,
  output logic [1:0]              axil_rresp,
  output logic                    axil_rvalid,
  input  logic                    axil_rready,
  output logic                    wb_cyc_o,
  output logic                    wb_stb_o,
  output logic                    wb_we_o,
  output logic [ADDR_WIDTH-1:0]   wb_adr_o,
  output logic [DATA_WIDTH-1:0]   wb_dat_o,
  output logic [DATA_WIDTH/8-1:0] wb_sel_o,
  input  logic [DATA_WIDTH-1:0]   wb_dat_i,
  input  logic                    wb_ack_i
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CW = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t              state;
  logic                aw_held, w_held;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic                last_grant_rd;
  logic [CW-1:0]       cnt;

  logic idle, aw_fire, w_fire, wr_full, rd_eligible, wr_sel, rd_sel;

  assign idle         = (state == IDLE) && !wb_rst_i;
  assign axil_awready = idle && !aw_held;
  assign axil_wready  = idle && !w_held;
  assign aw_fire      = axil_awvalid && axil_awready;
  assign w_fire       = axil_wvalid && axil_wready;
  assign wr_full      = idle && (aw_held || aw_fire) && (w_held || w_fire);
  assign rd_eligible  = idle && !aw_held && !w_held && axil_arvalid;
  // A complete write yields to a contending read only when the last grant was a write.
  assign wr_sel       = wr_full && (!rd_eligible || last_grant_rd);
  assign axil_arready = idle && !aw_held && !w_held && !wr_sel;
  assign rd_sel       = axil_arvalid && axil_arready;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state         <= IDLE;
      aw_held       <= 1'b0;
      w_held        <= 1'b0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      last_grant_rd <= 1'b1;
      cnt           <= '0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_adr_o      <= '0;
      wb_dat_o      <= '0;
      wb_sel_o      <= '0;
      axil_bresp    <= RESP_OKAY;
      axil_bvalid   <= 1'b0;
      axil_rdata    <= '0;
      axil_rresp    <= RESP_OKAY;
      axil_rvalid   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (aw_fire) begin
            aw_held  <= 1'b1;
            awaddr_q <= axil_awaddr;
          end
          if (w_fire) begin
            w_held  <= 1'b1;
            wdata_q <= axil_wdata;
            wstrb_q <= axil_wstrb;
          end
          if (wr_sel) begin
            aw_held       <= 1'b0;
            w_held        <= 1'b0;
            last_grant_rd <= 1'b0;
            cnt           <= '0;
            wb_cyc_o      <= 1'b1;
            wb_stb_o      <= 1'b1;
            wb_we_o       <= 1'b1;
            wb_adr_o      <= aw_held ? awaddr_q : axil_awaddr;
            wb_dat_o      <= w_held ? wdata_q : axil_wdata;
            wb_sel_o      <= w_held ? wstrb_q : axil_wstrb;
            state         <= WB_WR;
          end else if (rd_sel) begin
            last_grant_rd <= 1'b1;
            cnt           <= '0;
            wb_cyc_o      <= 1'b1;
            wb_stb_o      <= 1'b1;
            wb_we_o       <= 1'b0;
            wb_adr_o      <= axil_araddr;
            wb_dat_o      <= '0;
            wb_sel_o      <= '1;
            state         <= WB_RD;
          end
        end
        WB_WR, WB_RD: begin
          // Ack wins over expiry when both land in the same cycle.
          if (wb_ack_i || cnt == CNT_LAST) begin
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            if (state == WB_WR) begin
              axil_bresp  <= wb_ack_i ? RESP_OKAY : RESP_SLVERR;
              axil_bvalid <= 1'b1;
              state       <= B_RESP;
            end else begin
              axil_rdata  <= wb_ack_i ? wb_dat_i : '0;
              axil_rresp  <= wb_ack_i ? RESP_OKAY : RESP_SLVERR;
              axil_rvalid <= 1'b1;
              state       <= R_RESP;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        B_RESP: begin
          if (axil_bready) begin
            axil_bvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        R_RESP: begin
          if (axil_rready) begin
            axil_rvalid <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil2wb.sv
// Randomised scoreboard bench for axil2wb: a behavioural Wishbone slave plus a
// transaction-level model predicting Wishbone requests and AXI responses.
module tb_axil2wb;

  localparam int DW = 32;
  localparam int AW = 12;
  localparam int TO = 4;
  localparam int NEVER = 1000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] awaddr = '0, araddr = '0;
  logic          awvalid = 0, wvalid = 0, arvalid = 0, bready = 0, rready = 0;
  logic [DW-1:0] wdata = '0;
  logic [3:0]    wstrb = '0;
  logic          awready, wready, arready, bvalid, rvalid;
  logic [1:0]    bresp, rresp;
  logic [DW-1:0] rdata;
  logic          wb_cyc, wb_stb, wb_we;
  logic [AW-1:0] wb_adr;
  logic [DW-1:0] wb_dat_o;
  logic [3:0]    wb_sel;
  logic [DW-1:0] wb_dat_i = '0;
  logic          wb_ack = 1'b0;

  axil2wb #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .axil_awaddr(awaddr), .axil_awvalid(awvalid), .axil_awready(awready),
    .axil_wdata(wdata), .axil_wstrb(wstrb), .axil_wvalid(wvalid), .axil_wready(wready),
    .axil_bresp(bresp), .axil_bvalid(bvalid), .axil_bready(bready),
    .axil_araddr(araddr), .axil_arvalid(arvalid), .axil_arready(arready),
    .axil_rdata(rdata), .axil_rresp(rresp), .axil_rvalid(rvalid), .axil_rready(rready),
    .wb_cyc_o(wb_cyc), .wb_stb_o(wb_stb), .wb_we_o(wb_we), .wb_adr_o(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [AW-1:0] adr;
    logic [DW-1:0] dat;
    logic [3:0]    sel;
    int            ws;
  } wb_exp_t;
  typedef struct {
    logic [1:0]    resp;
    logic [DW-1:0] data;
  } rsp_t;

  wb_exp_t wbq[$];
  rsp_t    bq[$], rq[$];
  logic [DW-1:0] smem [0:1023];
  logic [DW-1:0] mmem [0:1023];
  logic    m_last_rd = 1'b1;
  int      checks = 0, errors = 0;
  int      r_hold = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] nw,
                                          input logic [3:0] sel);
    logic [DW-1:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // ---------------- Wishbone slave with its own memory ----------------
  logic active = 0;
  int   cur_ws = 0, wait_cnt = 0, hi_cycles = 0;
  always @(negedge clk) begin
    if (rst) begin
      wb_ack = 1'b0;
      active = 0;
    end else if (wb_ack) begin
      wb_ack = 1'b0;
      active = 0;
      check("wb_cyc_drop_after_ack", wb_cyc, 1'b0);
    end else if (wb_cyc && wb_stb) begin
      if (!active) begin
        wb_exp_t e;
        active = 1; wait_cnt = 0; hi_cycles = 0; cur_ws = NEVER;
        check("wb_req_expected", wbq.size() != 0, 1'b1);
        if (wbq.size() != 0) begin
          e = wbq.pop_front();
          cur_ws = e.ws;
          check("wb_we", wb_we, e.we);
          check("wb_adr", wb_adr, e.adr);
          check("wb_dat_o", wb_dat_o, e.dat);
          check("wb_sel", wb_sel, e.sel);
        end
      end
      hi_cycles++;
      if (wait_cnt == cur_ws) begin
        wb_ack = 1'b1;
        if (wb_we) smem[wb_adr[11:2]] = merge(smem[wb_adr[11:2]], wb_dat_o, wb_sel);
        else       wb_dat_i = smem[wb_adr[11:2]];
      end else begin
        wait_cnt++;
      end
    end else if (active) begin
      active = 0;
      check("wb_timeout_cycles", hi_cycles, TO);
    end
  end

  // ---------------- AXI response monitor ----------------
  logic          b_pend = 0, r_pend = 0;
  logic [1:0]    b_last, r_last_resp;
  logic [DW-1:0] r_last_data;
  always @(negedge clk) begin
    if (!rst) begin
      if (b_pend) begin
        check("b_hold_valid", bvalid, 1'b1);
        check("b_hold_resp", bresp, b_last);
      end
      if (r_pend) begin
        check("r_hold_valid", rvalid, 1'b1);
        check("r_hold_resp", rresp, r_last_resp);
        check("r_hold_data", rdata, r_last_data);
      end
      if (bvalid && bready) begin
        check("b_expected", bq.size() != 0, 1'b1);
        if (bq.size() != 0) check("bresp", bresp, bq.pop_front().resp);
      end
      if (rvalid && rready) begin
        rsp_t e;
        check("r_expected", rq.size() != 0, 1'b1);
        if (rq.size() != 0) begin
          e = rq.pop_front();
          check("rresp", rresp, e.resp);
          check("rdata", rdata, e.data);
        end
      end
      b_pend = bvalid && !bready; b_last = bresp;
      r_pend = rvalid && !rready; r_last_resp = rresp; r_last_data = rdata;
    end else begin
      b_pend = 0; r_pend = 0;
    end
  end

  // Ready drivers: random back-pressure, or forced low on demand.
  initial forever begin
    @(posedge clk); #1;
    bready = ($urandom_range(0, 3) != 0);
    if (r_hold > 0) begin
      rready = 1'b0;
      if (rvalid) r_hold--;
    end else begin
      rready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- Stimulus tasks (start/end just after posedge) ----------------
  task automatic wait_hs(input string name, ref logic rdy);
    int n = 0;
    forever begin
      @(negedge clk);
      if (rdy) break;
      n++;
      if (n > 200) begin check(name, 0, 1); break; end
    end
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input int dly, input logic [AW-1:0] a);
    repeat (dly) begin @(posedge clk); #1; end
    awaddr = a; awvalid = 1;
    wait_hs("aw_handshake_bound", awready);
    awvalid = 0;
  endtask

  task automatic send_w(input int dly, input logic [DW-1:0] d, input logic [3:0] s);
    repeat (dly) begin @(posedge clk); #1; end
    wdata = d; wstrb = s; wvalid = 1;
    wait_hs("w_handshake_bound", wready);
    wvalid = 0;
  endtask

  task automatic send_ar(input int dly, input logic [AW-1:0] a);
    repeat (dly) begin @(posedge clk); #1; end
    araddr = a; arvalid = 1;
    wait_hs("ar_handshake_bound", arready);
    arvalid = 0;
  endtask

  task automatic exp_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                           input int ws);
    bit ok = (ws < TO);
    wbq.push_back('{1'b1, a, d, s, ws});
    bq.push_back('{ok ? 2'b00 : 2'b10, '0});
    if (ok) mmem[a[11:2]] = merge(mmem[a[11:2]], d, s);
    m_last_rd = 1'b0;
  endtask

  task automatic exp_read(input logic [AW-1:0] a, input int ws);
    bit ok = (ws < TO);
    wbq.push_back('{1'b0, a, '0, 4'hF, ws});
    rq.push_back('{ok ? 2'b00 : 2'b10, ok ? mmem[a[11:2]] : '0});
    m_last_rd = 1'b1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((wbq.size() + bq.size() + rq.size()) != 0 && n < 1000) begin
      @(posedge clk); n++;
    end
    check("response_bound", n < 1000, 1'b1);
    #1;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [3:0] s,
                          input int ws, input int aw_dly, input int w_dly);
    exp_write(a, d, s, ws);
    fork
      send_aw(aw_dly, a);
      send_w(w_dly, d, s);
    join
    wait_idle();
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int ws);
    exp_read(a, ws);
    send_ar(0, a);
    wait_idle();
  endtask

  // Write and read offered in the same cycle; the grant alternates.
  task automatic do_pair(input logic [AW-1:0] wa, input logic [DW-1:0] d, input logic [3:0] s,
                         input int wws, input logic [AW-1:0] ra, input int rws);
    if (m_last_rd) begin
      exp_write(wa, d, s, wws); exp_read(ra, rws);
    end else begin
      exp_read(ra, rws); exp_write(wa, d, s, wws);
    end
    fork
      send_aw(0, wa);
      send_w(0, d, s);
      send_ar(0, ra);
    join
    wait_idle();
  endtask

  task automatic set_mem(input logic [AW-1:0] a, input logic [DW-1:0] v);
    smem[a[11:2]] = v;
    mmem[a[11:2]] = v;
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finish");
    $fatal(1, "time limit");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      smem[i] = 32'hA500_0000 + i;
      mmem[i] = 32'hA500_0000 + i;
    end
    repeat (3) @(negedge clk);
    check("rst_awready", awready, 0);
    check("rst_arready", arready, 0);
    check("rst_outputs", {wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, bvalid, rvalid, bresp, rresp}, '0);
    check("rst_rdata_wbdat", {rdata, wb_dat_o}, '0);
    @(posedge clk); #1; rst = 0;
    @(posedge clk); #1;

    // Same-cycle AW+W with zero wait states: cyc at cycle 1, bvalid at cycle 2.
    exp_write(12'h010, 32'h0000_0040, 4'hF, 0);
    fork
      send_aw(0, 12'h010);
      send_w(0, 32'h0000_0040, 4'hF);
      begin
        @(negedge clk); @(negedge clk);
        check("lat_cyc_cycle1", {wb_cyc, wb_stb, wb_we}, 3'b111);
        @(negedge clk);
        check("lat_bvalid_cycle2", {bvalid, bresp}, 3'b100);
      end
    join
    wait_idle();

    // W one cycle ahead of AW: no Wishbone cycle before the address arrives.
    exp_write(12'h080, 32'hDEAD_BEEF, 4'hF, 1);
    fork
      send_w(0, 32'hDEAD_BEEF, 4'hF);
      send_aw(1, 12'h080);
      begin
        @(negedge clk); @(negedge clk);
        check("no_early_cyc", wb_cyc, 1'b0);
      end
    join
    wait_idle();

    // Read with 3 wait states and a 2-cycle rready stall.
    set_mem(12'h084, 32'h0000_1234);
    r_hold = 2;
    do_read(12'h084, 3);

    // Timeouts, then a normal transaction.
    do_write(12'h100, 32'h1111_2222, 4'hF, NEVER, 0, 0);
    do_read(12'h104, NEVER);
    do_write(12'h104, 32'h5555_6666, 4'h3, 3, 0, 0);
    do_read(12'h104, 3);
    do_write(12'h108, 32'h7777_8888, 4'h0, 0, 1, 0);

    // Arbitration: write wins after a read grant, read wins after a write grant.
    do_pair(12'h200, 32'hCAFE_0001, 4'hF, 0, 12'h204, 1);
    do_pair(12'h208, 32'hCAFE_0002, 4'hF, 2, 12'h200, 0);
    do_write(12'h20C, 32'hCAFE_0003, 4'hF, 0, 0, 0);
    do_pair(12'h210, 32'hCAFE_0004, 4'hC, 1, 12'h20C, 0);

    // Partially captured write blocks a pending read.
    exp_write(12'h300, 32'h0BAD_F00D, 4'hF, 0);
    exp_read(12'h300, 0);
    fork
      send_aw(0, 12'h300);
      send_w(5, 32'h0BAD_F00D, 4'hF);
      send_ar(1, 12'h300);
      begin
        repeat (2) @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("arready_blocked_by_aw", arready, 1'b0);
        end
      end
    join
    wait_idle();

    // Random traffic.
    for (int t = 0; t < 60; t++) begin
      logic [AW-1:0] a, a2;
      logic [DW-1:0] d;
      logic [3:0] s;
      int ws, ws2, kind;
      a = AW'($urandom); a2 = AW'($urandom & 32'hFF);
      d = $urandom; s = 4'($urandom);
      ws = $urandom_range(0, 5); ws2 = $urandom_range(0, 5);
      kind = $urandom_range(0, 3);
      if (ws == 5) ws = NEVER;
      case (kind)
        0, 1: do_write(a, d, s, ws, $urandom_range(0, 3), $urandom_range(0, 3));
        2:    do_read(a, ws);
        default: do_pair(a, d, s, ws, a2, ws2);
      endcase
    end

    // Reset while a Wishbone cycle is open: everything drops, no response follows.
    exp_write(12'h400, 32'h1234_5678, 4'hF, NEVER);
    fork
      send_aw(0, 12'h400);
      send_w(0, 32'h1234_5678, 4'hF);
    join
    begin
      int n = 0;
      while (!wb_cyc && n < 20) begin @(posedge clk); n++; end
      check("cyc_seen_before_reset", n < 20, 1'b1);
    end
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_cyc_stb_bvalid", {wb_cyc, wb_stb, bvalid}, 3'b000);
    wbq.delete(); bq.delete(); rq.delete();
    m_last_rd = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("no_resp_after_abort", {bvalid, rvalid}, 2'b00);
    do_write(12'h404, 32'h9ABC_DEF0, 4'hF, 0, 0, 0);
    do_read(12'h404, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
